// File: rtl/recompute_unit_controller_os_pkg.sv
// recompute_unit_controller_os_pkg: FSM states and index-width helper shared by the OS recompute-unit controller.
package recompute_unit_controller_os_pkg;

    typedef enum logic [1:0] {IDLE, SCAN, STREAM, DRAIN} state_t;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/recompute_unit_controller_os_ru_fault_scanner.sv
// ru_fault_scanner: priority finder returning the first NUM_RU faulty PEs (ascending r*COLS+c) of the pass/fail map.
module ru_fault_scanner
    import recompute_unit_controller_os_pkg::*;
#(
    parameter int ROWS   = 4,
    parameter int COLS   = 4,
    parameter int NUM_RU = 4,
    localparam int IW    = idx_w(COLS)
) (
    input  logic [ROWS*COLS-1:0] map,
    output logic [IW*NUM_RU-1:0] row_idx,
    output logic [IW*NUM_RU-1:0] col_idx,
    output logic [NUM_RU-1:0]    valid,
    output logic                 overflow
);

    always_comb begin
        int n;
        row_idx  = '0;
        col_idx  = '0;
        valid    = '0;
        overflow = 1'b0;
        n        = 0;
        for (int p = 0; p < ROWS*COLS; p++) begin
            if (!map[p]) begin
                if (n < NUM_RU) begin
                    row_idx[n*IW +: IW] = IW'(p / COLS);
                    col_idx[n*IW +: IW] = IW'(p % COLS);
                    valid[n]            = 1'b1;
                end else begin
                    overflow = 1'b1;
                end
                n++;
            end
        end
    end

endmodule

// File: rtl/recompute_unit_controller_os.sv
// recompute_unit_controller_os: assigns faulty PEs to recompute units and streams their operands.
// Optional RU_OVERFLOW_FLAG_EN adds ru_overflow, flagging more faults than recompute units.
module recompute_unit_controller_os
    import recompute_unit_controller_os_pkg::*;
#(
    parameter int ROWS      = 4,
    parameter int COLS      = 4,
    parameter int WORD_SIZE = 16,
    parameter int NUM_RU    = 4,
    localparam int IW       = idx_w(COLS),
    localparam int KW       = idx_w(COLS + 1)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [ROWS*COLS*WORD_SIZE-1:0] top_matrix,
    input  logic [ROWS*COLS*WORD_SIZE-1:0] left_matrix,
    input  logic [ROWS*COLS-1:0]          STW_result_mat,
    output logic [NUM_RU-1:0]             ru_en,
    output logic [NUM_RU*WORD_SIZE-1:0]   ru_top_inputs,
    output logic [NUM_RU*WORD_SIZE-1:0]   ru_left_inputs,
    output logic [NUM_RU-1:0]             ru_set_stationary,
    output logic [NUM_RU-1:0]             ru_fsm_out_sel_in,
    output logic [NUM_RU-1:0]             ru_stat_bit_in,
    output logic [IW*NUM_RU-1:0]          ru_col_mapping,
`ifdef RU_OVERFLOW_FLAG_EN
    output logic                          ru_overflow,
`endif
    output logic [IW*NUM_RU-1:0]          ru_row_mapping
);

    state_t                      state;
    logic [ROWS*COLS-1:0]        map_q;
    logic [KW-1:0]               k;
    logic [NUM_RU-1:0]           assigned;
    logic                        overflow_q;
    logic [IW*NUM_RU-1:0]        sc_row, sc_col;
    logic [NUM_RU-1:0]           sc_valid;
    logic                        sc_more;
    logic [IW*NUM_RU-1:0]        src_row, src_col;
    logic [NUM_RU-1:0]           src_valid;
    logic [KW-1:0]               src_k;
    logic [NUM_RU*WORD_SIZE-1:0] nxt_top, nxt_left;

    ru_fault_scanner #(.ROWS(ROWS), .COLS(COLS), .NUM_RU(NUM_RU)) u_scanner (
        .map      (map_q),
        .row_idx  (sc_row),
        .col_idx  (sc_col),
        .valid    (sc_valid),
        .overflow (sc_more)
    );

    // In SCAN the first operands are fetched straight from the scanner, before the mapping is latched.
    assign src_row   = (state == SCAN) ? sc_row   : ru_row_mapping;
    assign src_col   = (state == SCAN) ? sc_col   : ru_col_mapping;
    assign src_valid = (state == SCAN) ? sc_valid : assigned;
    assign src_k     = (state == SCAN) ? '0       : k;

    always_comb begin
        int r, c;
        nxt_top  = '0;
        nxt_left = '0;
        r        = 0;
        c        = 0;
        for (int i = 0; i < NUM_RU; i++) begin
            r = int'(src_row[i*IW +: IW]);
            c = int'(src_col[i*IW +: IW]);
            if (src_valid[i]) begin
                nxt_left[i*WORD_SIZE +: WORD_SIZE] = left_matrix[(r*COLS + int'(src_k))*WORD_SIZE +: WORD_SIZE];
                nxt_top[i*WORD_SIZE +: WORD_SIZE]  = top_matrix[(int'(src_k)*COLS + c)*WORD_SIZE +: WORD_SIZE];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state             <= IDLE;
            map_q             <= '1;
            k                 <= '0;
            assigned          <= '0;
            overflow_q        <= 1'b0;
            ru_en             <= '0;
            ru_top_inputs     <= '0;
            ru_left_inputs    <= '0;
            ru_set_stationary <= '0;
            ru_fsm_out_sel_in <= '0;
            ru_stat_bit_in    <= '0;
            ru_col_mapping    <= '0;
            ru_row_mapping    <= '0;
        end else if (STW_result_mat != map_q) begin
            // A map change aborts whatever is in flight and rescans.
            map_q             <= STW_result_mat;
            state             <= SCAN;
            ru_en             <= '0;
            ru_set_stationary <= '0;
            ru_fsm_out_sel_in <= '0;
            ru_stat_bit_in    <= '0;
        end else begin
            case (state)
                SCAN: begin
                    ru_row_mapping <= sc_row;
                    ru_col_mapping <= sc_col;
                    assigned       <= sc_valid;
                    overflow_q     <= sc_more;
                    k              <= KW'(1);
                    if (|sc_valid) begin
                        state             <= STREAM;
                        ru_en             <= sc_valid;
                        ru_stat_bit_in    <= sc_valid;
                        ru_set_stationary <= sc_valid;
                        ru_top_inputs     <= nxt_top;
                        ru_left_inputs    <= nxt_left;
                    end else begin
                        state <= IDLE;
                    end
                end
                STREAM: begin
                    ru_set_stationary <= '0;
                    if (k == KW'(COLS)) begin
                        state             <= DRAIN;
                        ru_en             <= '0;
                        ru_stat_bit_in    <= '0;
                        ru_fsm_out_sel_in <= assigned;
                    end else begin
                        ru_top_inputs  <= nxt_top;
                        ru_left_inputs <= nxt_left;
                        k              <= k + KW'(1);
                    end
                end
                DRAIN: begin
                    ru_fsm_out_sel_in <= '0;
                    state             <= IDLE;
                end
                default: ;
            endcase
        end
    end

`ifdef RU_OVERFLOW_FLAG_EN
    assign ru_overflow = overflow_q;
`else
    logic unused_overflow;
    assign unused_overflow = overflow_q;
`endif

endmodule

// File: tb/tb_recompute_unit_controller_os.sv
// tb_recompute_unit_controller_os: directed self-checking bench for the OS recompute-unit controller.
module tb_recompute_unit_controller_os;

    localparam int R = 4, C = 4, W = 16, N = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic [R*C*W-1:0] top_m, left_m;
    logic [R*C-1:0]   map;
    logic [N-1:0]     ru_en, ru_set, ru_sel, ru_stat;
    logic [N*W-1:0]   ru_top, ru_left;
    logic [2*N-1:0]   col_map, row_map;
`ifdef RU_OVERFLOW_FLAG_EN
    logic             ovf;
`endif

    int tests = 0, fails = 0;
    logic [63:0] el [4];
    logic [63:0] et [4];
    int wm [16] = '{7, 2, 3, 5, 0, 7, 8, 6, 2, 3, 12, 5, 5, 1, 4, 9};

    recompute_unit_controller_os #(.ROWS(R), .COLS(C), .WORD_SIZE(W), .NUM_RU(N)) dut (
        .clk               (clk),
        .rst               (rst),
        .top_matrix        (top_m),
        .left_matrix       (left_m),
        .STW_result_mat    (map),
        .ru_en             (ru_en),
        .ru_top_inputs     (ru_top),
        .ru_left_inputs    (ru_left),
        .ru_set_stationary (ru_set),
        .ru_fsm_out_sel_in (ru_sel),
        .ru_stat_bit_in    (ru_stat),
        .ru_col_mapping    (col_map),
`ifdef RU_OVERFLOW_FLAG_EN
        .ru_overflow       (ovf),
`endif
        .ru_row_mapping    (row_map)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic stream_phase(input string tag, input logic [3:0] en_exp);
        for (int k = 0; k < C; k++) begin
            check($sformatf("%s en k%0d", tag, k), 64'(ru_en), 64'(en_exp));
            check($sformatf("%s stat k%0d", tag, k), 64'(ru_stat), 64'(en_exp));
            check($sformatf("%s set k%0d", tag, k), 64'(ru_set), (k == 0) ? 64'(en_exp) : 64'h0);
            check($sformatf("%s left k%0d", tag, k), ru_left, el[k]);
            check($sformatf("%s top k%0d", tag, k), ru_top, et[k]);
            tick();
        end
        check({tag, " drain en"}, 64'(ru_en), 64'h0);
        check({tag, " drain stat"}, 64'(ru_stat), 64'h0);
        check({tag, " drain sel"}, 64'(ru_sel), 64'(en_exp));
        tick();
        check({tag, " idle sel"}, 64'(ru_sel), 64'h0);
        check({tag, " idle en"}, 64'(ru_en), 64'h0);
    endtask

    initial begin
        for (int p = 0; p < 16; p++) begin
            top_m[(15-p)*W +: W]  = 16'(wm[p]);
            left_m[(15-p)*W +: W] = 16'(wm[p]);
        end
        top_m[11*W +: W]  = 16'd1;
        left_m[11*W +: W] = 16'd4;
        map = '1;
        repeat (3) tick();
        check("reset en", 64'(ru_en), 64'h0);
        check("reset left", ru_left, 64'h0);
        check("reset colmap", 64'(col_map), 64'h0);
        rst = 1'b1;
        repeat (3) tick();
        check("idle en", 64'(ru_en), 64'h0);
        check("idle sel", 64'(ru_sel), 64'h0);

        // two faults: (0,1) and (1,2)
        map = 16'b1111_1111_1011_1101;
        tick();
        check("scan en", 64'(ru_en), 64'h0);
        tick();
        check("A colmap", 64'(col_map), 64'h09);
        check("A rowmap", 64'(row_map), 64'h04);
        el = '{64'h0000_0000_0005_0009, 64'h0000_0000_000C_0004, 64'h0000_0000_0003_0001, 64'h0000_0000_0002_0005};
        et = '{64'h0000_0000_0001_0004, 64'h0000_0000_0003_000C, 64'h0000_0000_0007_0008, 64'h0000_0000_0002_0003};
        stream_phase("A", 4'b0011);

        // all pass after a recompute
        map = '1;
        tick();
        check("clear scan en", 64'(ru_en), 64'h0);
        tick();
        check("clear en", 64'(ru_en), 64'h0);
        check("clear colmap", 64'(col_map), 64'h0);
        tick();
        check("clear en2", 64'(ru_en), 64'h0);

        // abort two cycles into the stream
        map = 16'b1111_1111_1011_1101;
        repeat (3) tick();
        check("pre-abort en", 64'(ru_en), 64'h3);
        map = 16'b1111_1011_1111_1101;
        tick();
        check("abort en", 64'(ru_en), 64'h0);
        tick();
        check("B colmap", 64'(col_map), 64'h09);
        check("B rowmap", 64'(row_map), 64'h08);
        el = '{64'h0000_0000_0006_0009, 64'h0000_0000_0008_0004, 64'h0000_0000_0007_0001, 64'h0000_0000_0004_0005};
        stream_phase("B", 4'b0011);

        // five faults: indices 0,3,5,10,15
        map = 16'b0111_1011_1101_0110;
        repeat (2) tick();
        check("C en", 64'(ru_en), 64'hF);
        check("C colmap", 64'(col_map), 64'h9C);
        check("C rowmap", 64'(row_map), 64'h90);
        check("C left", ru_left, 64'h0006_0005_0009_0009);
        check("C top", ru_top, 64'h0001_0004_0005_0009);
`ifdef RU_OVERFLOW_FLAG_EN
        check("C overflow", 64'(ovf), 64'h1);
`endif
        tick();
        rst  = 1'b0;
        map  = '1;
        #1;
        check("rst en", 64'(ru_en), 64'h0);
        check("rst left", ru_left, 64'h0);
        check("rst rowmap", 64'(row_map), 64'h0);
        check("rst set", 64'(ru_set), 64'h0);
        tick();
        rst = 1'b1;
        repeat (4) tick();
        check("post-rst en", 64'(ru_en), 64'h0);
        check("post-rst sel", 64'(ru_sel), 64'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/recompute_unit_controller_os.md
Name: recompute_unit_controller_os

Overview:
Controller for the output-stationary (OS) recompute-unit (RU) repair path of the systolic array BISR.
- Watches the self-test (STW) pass/fail map of the PE grid.
- Assigns each failing PE to one redundant RU.
- Streams that PE's dot-product operands from the top and left matrices into the RU.
- Publishes the row/column mapping so downstream logic substitutes RU results for the faulty PE outputs.

Parameters:
- ROWS, 4, PE rows in the array.
- COLS, 4, PE columns in the array; also the reduction length K. Requires ROWS <= COLS.
- WORD_SIZE, 16, operand width in bits.
- NUM_RU, 4, number of recompute units.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- top_matrix  in  ROWS*COLS*WORD_SIZE  element (r,c) at bits [(r*COLS+c)*WORD_SIZE +: WORD_SIZE].
- left_matrix  in  ROWS*COLS*WORD_SIZE  same packing as top_matrix.
- STW_result_mat  in  ROWS*COLS  bit r*COLS+c: 1 = PE(r,c) passed, 0 = faulty.
- ru_en  out  NUM_RU  RU i consumes operands this cycle.
- ru_top_inputs  out  NUM_RU*WORD_SIZE  top operand for RU i at [i*WORD_SIZE +: WORD_SIZE].
- ru_left_inputs  out  NUM_RU*WORD_SIZE  left operand for RU i, same slicing.
- ru_set_stationary  out  NUM_RU  clears the RU accumulator on the first operand.
- ru_fsm_out_sel_in  out  NUM_RU  selects the accumulator onto the RU output.
- ru_stat_bit_in  out  NUM_RU  stationary/accumulate mode bit.
- ru_col_mapping  out  $clog2(COLS)*NUM_RU  column of the PE served by RU i.
- ru_row_mapping  out  $clog2(COLS)*NUM_RU  row of the PE served by RU i.

Behaviour:
- Reset (rst=0, asynchronous): state IDLE; all outputs 0; stored map all ones (no faults); k=0.
- Every cycle the input map is compared with the stored map. Any difference loads the new map and forces state SCAN next cycle, from any state. A map change therefore aborts an in-flight recompute and restarts it.
- SCAN (1 cycle): walk PE indices r*COLS+c in ascending order. The first NUM_RU zero bits are assigned to RU0, RU1, and so on. Latch the row/column mapping.
  - Unassigned RUs: mapping 0, all control bits 0.
  - Faults beyond NUM_RU are ignored.
  - No faults: go to IDLE.
- STREAM (COLS cycles, k = 0..COLS-1), for each assigned RU i serving PE(r,c):
  - ru_en[i]=1 and ru_stat_bit_in[i]=1.
  - ru_left_inputs[i] = left[r][k]; ru_top_inputs[i] = top[k][c].
  - ru_set_stationary[i]=1 only when k=0.
  - Operand outputs are registered.
- DRAIN (1 cycle): ru_en=0, ru_stat_bit_in=0, ru_fsm_out_sel_in[i]=1 for assigned RUs; then IDLE.
- IDLE: ru_en, ru_set_stationary, ru_fsm_out_sel_in and ru_stat_bit_in are all 0. Mappings are held until the next SCAN.
- Latency: map change sampled at edge E gives SCAN during cycle E..E+1. First STREAM outputs appear after edge E+1; DRAIN follows after edge E+1+COLS.
- Matrix inputs are read combinationally each STREAM cycle. Changes to them mid-stream are used as-is.

Optional Feature:
- RU_OVERFLOW_FLAG_EN defined: extra output ru_overflow (1 bit).
  - Set in SCAN when more than NUM_RU faulty PEs exist; cleared in SCAN otherwise.
  - Reset 0.
- Undefined: the port is absent and the extra faults are silently dropped.

Decomposition:
- Shared package: FSM state enum (IDLE, SCAN, STREAM, DRAIN) and index-width constants (clog2 of COLS).
- One natural sub-module, ru_fault_scanner: combinational priority finder returning the first NUM_RU faulty PE (row, col, valid) tuples.

Test Plan:
Common setup: 4x4 array, NUM_RU=4, with top_matrix and left_matrix packed from the element sequence {7,2,3,5,1|4,7,8,6,2,3,12,5,5,1,4,9}, listed MSB first. The fifth word is 1 for top_matrix and 4 for left_matrix. Row 0 of left is 9,4,1,5; top column 1 is 4,12,8,3.
- Reset with map all ones, then release -> outputs stay 0; state IDLE.
- Map 16'b1111_1111_1011_1101 ->
  - RU0 maps (0,1) and RU1 maps (1,2); ru_en=4'b0011 for 4 cycles.
  - RU0 streams left 9,4,1,5 against top 4,12,8,3.
  - RU1 streams left 5,12,3,2 against top 1,3,7,2.
  - ru_set_stationary=4'b0011 on the first stream cycle only; ru_fsm_out_sel_in=4'b0011 one cycle after the stream.
- Map changed to 16'b1111_1011_1111_1101 two cycles into the stream -> stream aborted; rescan assigns RU0=(0,1), RU1=(2,2); fresh 4-cycle stream; RU1 left operands 6,8,7,4.
- Map all ones after a recompute -> SCAN then IDLE; ru_en stays 0.
- Five zeros in the map -> only the four lowest indices are assigned; with RU_OVERFLOW_FLAG_EN, ru_overflow=1.
- Assert rst mid-STREAM -> all outputs 0 immediately; no stream resumes until the map differs from all ones.
